k8088_bus: RTL and testbench
============================

K8088_BUS -- requirements
Module: k8088_bus

Interface
REQ-001 Parameter WAIT_MAX, default 8'd255: maximum mem_ack wait cycles before timeout.
REQ-002 Parameter ROM_BASE, default 20'hF0000: lowest write-protected address (used only under K8088_BUS_WP_EN).
REQ-003 clock  in  1  single system clock; all logic on posedge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 cpu_address  in  20  CPU bus address (combinational from core).
REQ-006 cpu_out  in  8  CPU write data.
REQ-007 cpu_we  in  1  CPU write strobe (registered in core).
REQ-008 cpu_chipen  out  1  CPU step enable; one-clock pulse per completed access.
REQ-009 cpu_in  out  8  read data to CPU, registered.
REQ-010 mem_address  out  20  latched access address.
REQ-011 mem_wdata  out  8  latched write data.
REQ-012 mem_we  out  1  write qualifier, valid while mem_req=1.
REQ-013 mem_req  out  1  access request, held until ack.
REQ-014 mem_rdata  in  8  memory read data, valid with mem_ack.
REQ-015 mem_ack  in  1  access completion, sampled only while mem_req=1.
REQ-016 bus_err  out  1  sticky timeout flag.
REQ-017 wp_hit  out  1  one-clock pulse on blocked write.

Function
REQ-018 FSM states ISSUE, WAIT, STEP; exactly one active.
REQ-019 ISSUE: latch cpu_address->mem_address, cpu_out->mem_wdata, cpu_we->mem_we; mem_req<=1; clear wait counter; next WAIT.
REQ-020 WAIT: mem_req held 1, mem_address/mem_wdata/mem_we stable; counter increments per cycle.
REQ-021 WAIT with mem_ack=1: mem_req<=0; cpu_in<=mem_rdata for reads, mem_wdata for writes; next STEP.
REQ-022 WAIT with mem_ack=0 and counter==WAIT_MAX: mem_req<=0, cpu_in<=8'hFF, bus_err<=1, next STEP.
REQ-023 mem_ack and timeout same cycle: ack wins, no bus_err.
REQ-024 STEP: cpu_chipen=1 for exactly this one cycle; next ISSUE.
REQ-025 cpu_chipen=0 in ISSUE and WAIT; never two consecutive high cycles.
REQ-026 Minimum step period 3 clocks (ack on first WAIT cycle); period = 3 + extra wait cycles.
REQ-027 cpu_in stable from WAIT exit until next WAIT exit.
REQ-028 mem_ack outside WAIT ignored.
REQ-029 Counter 8 bits, no wrap; saturates at timeout.
REQ-030 bus_err cleared only by reset.

Reset
REQ-031 reset_n=0 at a posedge: state<=ISSUE, cpu_chipen=0, mem_req=0, mem_we=0, cpu_in=8'hFF, mem_address=0, mem_wdata=0, bus_err=0, wp_hit=0, counter=0.
REQ-032 Reset during WAIT: mem_req low after that edge; pending ack discarded; no cpu_chipen pulse.
REQ-033 First access issued in ISSUE on first clock with reset_n=1 (CPU reset vector FFFF0).

Configuration
REQ-034 Macro K8088_BUS_WP_EN defined: ISSUE with cpu_we=1 and cpu_address>=ROM_BASE forces mem_we<=0 (access proceeds as read), pulses wp_hit one clock, cpu_in<=mem_rdata.
REQ-035 Macro undefined: all writes forwarded; wp_hit tied 0; ROM_BASE unused.

Verification
REQ-036 Reset release, mem_ack one cycle after mem_req rises, mem_rdata=8'hEA -> mem_address=20'hFFFF0, cpu_in=8'hEA, cpu_chipen pulse 3 clocks after ISSUE, period 3.
REQ-037 Write cpu_address=20'h00400, cpu_out=8'h5A, cpu_we=1, ack after 4 wait cycles -> mem_we=1, mem_wdata=8'h5A held stable all WAIT cycles, step period 7.
REQ-038 mem_ack held 0 -> mem_req drops after WAIT_MAX cycles, cpu_in=8'hFF, bus_err=1, stays 1 after later good accesses.
REQ-039 reset_n=0 asserted on 2nd WAIT cycle, ack next cycle -> mem_req=0 after edge, no cpu_chipen, restarts at ISSUE.
REQ-040 K8088_BUS_WP_EN defined, write 8'h11 to 20'hF0010 -> mem_we=0, wp_hit one pulse; write to 20'hEFFFF -> mem_we=1, no wp_hit.
REQ-041 mem_ack and timeout coincide at counter==WAIT_MAX, mem_rdata=8'h3C -> cpu_in=8'h3C, bus_err=0.

Source files
------------

// File: rtl/k8088_bus.sv
// rtl/k8088_bus.sv - 8088 core to memory bus sequencer: ISSUE/WAIT/STEP handshake with ack timeout.
// Optional write protection of addresses >= ROM_BASE is enabled by defining K8088_BUS_WP_EN.
module k8088_bus #(
    parameter logic [7:0]  WAIT_MAX = 8'd255,
    parameter logic [19:0] ROM_BASE = 20'hF0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [19:0] cpu_address,
    input  logic [7:0]  cpu_out,
    input  logic        cpu_we,
    output logic        cpu_chipen,
    output logic [7:0]  cpu_in,
    output logic [19:0] mem_address,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_req,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err,
    output logic        wp_hit
);

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_WAIT  = 2'd1,
        S_STEP  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic       wp_en;
    logic       wp_block;
    logic       timeout;

`ifdef K8088_BUS_WP_EN
    assign wp_en = 1'b1;
`else
    assign wp_en = 1'b0;
`endif

    // A blocked write is turned into a read so the CPU still gets a normal step.
    assign wp_block = wp_en && cpu_we && (cpu_address >= ROM_BASE);
    assign timeout  = !mem_ack && (wait_cnt == WAIT_MAX);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= S_ISSUE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = S_ISSUE;
        case (state)
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  state_next = (mem_ack || timeout) ? S_STEP : S_WAIT;
            S_STEP:  state_next = S_ISSUE;
            default: state_next = S_ISSUE;
        endcase
    end

    always_comb begin
        cpu_chipen = (state == S_STEP);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            mem_address <= 20'h0;
            mem_wdata   <= 8'h0;
            mem_we      <= 1'b0;
            mem_req     <= 1'b0;
            cpu_in      <= 8'hFF;
            bus_err     <= 1'b0;
            wp_hit      <= 1'b0;
            wait_cnt    <= 8'h0;
        end else begin
            case (state)
                S_ISSUE: begin
                    mem_address <= cpu_address;
                    mem_wdata   <= cpu_out;
                    mem_we      <= cpu_we && !wp_block;
                    mem_req     <= 1'b1;
                    wait_cnt    <= 8'h0;
                    wp_hit      <= wp_block;
                end
                S_WAIT: begin
                    wp_hit <= 1'b0;
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        cpu_in  <= mem_we ? mem_wdata : mem_rdata;
                    end else if (timeout) begin
                        mem_req <= 1'b0;
                        cpu_in  <= 8'hFF;
                        bus_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    wp_hit <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_k8088_bus.sv
// tb/tb_k8088_bus.sv - directed self-checking bench for k8088_bus (WAIT_MAX overridden to 6).
module tb_k8088_bus;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [19:0] cpu_address;
    logic [7:0]  cpu_out;
    logic        cpu_we;
    logic        cpu_chipen;
    logic [7:0]  cpu_in;
    logic [19:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_req;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        bus_err;
    logic        wp_hit;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_pulse = -100;
    int period = 0;
    int pulses = 0;
    int consec = 0;
    int p0 = 0;
    logic prev_chip = 1'b0;
    logic ok;

    always #5 clock = ~clock;

    k8088_bus #(.WAIT_MAX(8'd6)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cpu_address (cpu_address),
        .cpu_out     (cpu_out),
        .cpu_we      (cpu_we),
        .cpu_chipen  (cpu_chipen),
        .cpu_in      (cpu_in),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_req     (mem_req),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .bus_err     (bus_err),
        .wp_hit      (wp_hit)
    );

    // Step-pulse monitor: period between pulses and back-to-back detection.
    always @(negedge clock) begin
        cyc = cyc + 1;
        if (cpu_chipen === 1'b1) begin
            period = cyc - last_pulse;
            last_pulse = cyc;
            pulses = pulses + 1;
            if (prev_chip) consec = consec + 1;
        end
        prev_chip = (cpu_chipen === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Entered during ISSUE; returns half a cycle into STEP.
    task automatic access(input int extra, input logic [7:0] rd, output logic stable);
        logic [19:0] a;
        logic [7:0]  w;
        logic        we;
        tick();
        stable = 1'b1;
        a = mem_address;
        w = mem_wdata;
        we = mem_we;
        for (int i = 0; i <= extra; i++) begin
            if (i > 0) tick();
            if (mem_req !== 1'b1 || mem_address !== a || mem_wdata !== w ||
                mem_we !== we || cpu_chipen !== 1'b0) stable = 1'b0;
        end
        mem_ack = 1'b1;
        mem_rdata = rd;
        tick();
        mem_ack = 1'b0;
        @(negedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        cpu_address = 20'hFFFF0;
        cpu_out = 8'h00;
        cpu_we = 1'b0;
        mem_rdata = 8'h00;
        mem_ack = 1'b0;
        tick();
        tick();
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_cpu_in", {24'd0, cpu_in}, 32'hFF);
        chk("rst_chipen", {31'd0, cpu_chipen}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst_mem_address", {12'd0, mem_address}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_wp_hit", {31'd0, wp_hit}, 32'd0);

        reset_n = 1'b1;
        access(0, 8'hEA, ok);
        chk("rd1_stable", {31'd0, ok}, 32'd1);
        chk("rd1_chipen", {31'd0, cpu_chipen}, 32'd1);
        chk("rd1_cpu_in", {24'd0, cpu_in}, 32'hEA);
        chk("rd1_mem_address", {12'd0, mem_address}, 32'hFFFF0);
        chk("rd1_mem_req", {31'd0, mem_req}, 32'd0);
        tick();
        chk("issue_chipen_low", {31'd0, cpu_chipen}, 32'd0);

        access(0, 8'h12, ok);
        chk("rd2_cpu_in", {24'd0, cpu_in}, 32'h12);
        chk("rd2_period", period, 32'd3);
        tick();

        cpu_address = 20'h00400;
        cpu_out = 8'h5A;
        cpu_we = 1'b1;
        access(4, 8'hC3, ok);
        chk("wr_stable", {31'd0, ok}, 32'd1);
        chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
        chk("wr_mem_wdata", {24'd0, mem_wdata}, 32'h5A);
        chk("wr_cpu_in", {24'd0, cpu_in}, 32'h5A);
        chk("wr_period", period, 32'd7);
        tick();

        cpu_address = 20'h00123;
        cpu_we = 1'b0;
        access(6, 8'h3C, ok);
        chk("coin_cpu_in", {24'd0, cpu_in}, 32'h3C);
        chk("coin_bus_err", {31'd0, bus_err}, 32'd0);
        chk("coin_period", period, 32'd9);
        tick();

        cpu_address = 20'h00200;
        tick();
        chk("rw_req_up", {31'd0, mem_req}, 32'd1);
        tick();
        reset_n = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 8'h55;
        p0 = pulses;
        tick();
        chk("rw_req_dropped", {31'd0, mem_req}, 32'd0);
        chk("rw_chipen", {31'd0, cpu_chipen}, 32'd0);
        chk("rw_cpu_in", {24'd0, cpu_in}, 32'hFF);
        reset_n = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("rw_reissue_req", {31'd0, mem_req}, 32'd1);
        chk("rw_reissue_addr", {12'd0, mem_address}, 32'h00200);
        tick();
        chk("rw_ack_in_issue_ignored", {31'd0, mem_req}, 32'd1);
        chk("rw_no_pulse", pulses, p0);
        mem_ack = 1'b1;
        mem_rdata = 8'h66;
        tick();
        mem_ack = 1'b0;
        chk("rw_done_chipen", {31'd0, cpu_chipen}, 32'd1);
        chk("rw_done_cpu_in", {24'd0, cpu_in}, 32'h66);
        tick();

        cpu_address = 20'h00300;
        tick();
        repeat (6) tick();
        chk("to_req_before", {31'd0, mem_req}, 32'd1);
        chk("to_err_before", {31'd0, bus_err}, 32'd0);
        tick();
        chk("to_req_dropped", {31'd0, mem_req}, 32'd0);
        chk("to_cpu_in", {24'd0, cpu_in}, 32'hFF);
        chk("to_bus_err", {31'd0, bus_err}, 32'd1);
        chk("to_chipen", {31'd0, cpu_chipen}, 32'd1);
        tick();

        access(1, 8'h77, ok);
        chk("post_to_cpu_in", {24'd0, cpu_in}, 32'h77);
        chk("post_to_bus_err", {31'd0, bus_err}, 32'd1);
        tick();

        cpu_address = 20'hF0010;
        cpu_out = 8'h11;
        cpu_we = 1'b1;
        tick();
`ifdef K8088_BUS_WP_EN
        chk("wp_rom_mem_we", {31'd0, mem_we}, 32'd0);
        chk("wp_rom_hit", {31'd0, wp_hit}, 32'd1);
`else
        chk("wp_rom_mem_we", {31'd0, mem_we}, 32'd1);
        chk("wp_rom_hit", {31'd0, wp_hit}, 32'd0);
`endif
        mem_ack = 1'b1;
        mem_rdata = 8'h99;
        tick();
        mem_ack = 1'b0;
        chk("wp_hit_one_pulse", {31'd0, wp_hit}, 32'd0);
`ifdef K8088_BUS_WP_EN
        chk("wp_rom_cpu_in", {24'd0, cpu_in}, 32'h99);
`else
        chk("wp_rom_cpu_in", {24'd0, cpu_in}, 32'h11);
`endif
        tick();

        cpu_address = 20'hEFFFF;
        tick();
        chk("wp_ram_mem_we", {31'd0, mem_we}, 32'd1);
        chk("wp_ram_hit", {31'd0, wp_hit}, 32'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();

        chk("no_back_to_back_chipen", consec, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
